multicycle_control_fsm: RTL and testbench

Multi-cycle control sequencer for the RISC-V core. Decodes the instruction held in the instruction register and steps the shared ALU, single unified memory port, register file and PC through one state per cycle. Produces every datapath select/enable strobe, and replaces the single-cycle decoder when the core is built multi-cycle. Supports lw, sw, R-type, I-type ALU, beq/bne and jal.

---
 rtl/multicycle_control_fsm.sv | 90 +++++++++
 tb/tb_multicycle_control_fsm.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RISC-V control sequencer (lw, sw, R/I-type, beq/bne, jal).
// Define MEM_WAIT_EN to add the MemReady port and hold FETCH/MEMREAD/MEMWRITE until memory completes.
module multicycle_control_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] opcode,
  input  logic       funct3_0,
  input  logic       Zero,
`ifdef MEM_WAIT_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       IllegalOp
);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8, JAL = 4'd9, BRANCH = 4'd10
  } state_t;
  state_t state;
  logic rdy, supported, pc_update, branch, irw, mw, rw;
`ifdef MEM_WAIT_EN
  assign rdy = MemReady;
`else
  assign rdy = 1'b1;
`endif
  assign supported = opcode inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR};
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= FETCH;
    else
      case (state)
        FETCH:    state <= rdy ? DECODE : FETCH;
        DECODE:   state <= (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                           opcode == OP_R   ? EXECR  :
                           opcode == OP_I   ? EXECI  :
                           opcode == OP_JAL ? JAL    :
                           opcode == OP_BR  ? BRANCH : FETCH;
        MEMADR:   state <= opcode == OP_SW ? MEMWRITE : MEMREAD;
        MEMREAD:  state <= rdy ? MEMWB : MEMREAD;
        MEMWRITE: state <= rdy ? FETCH : MEMWRITE;
        EXECR, EXECI, JAL: state <= ALUWB;
        default:  state <= FETCH;
      endcase
  // Moore decode; codes 11-15 fall through to all-zero strobes
  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    irw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      FETCH:    begin irw = rdy; pc_update = rdy; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWRITE: begin AdrSrc = 1'b1; mw = 1'b1; end
      MEMWB:    begin ResultSrc = 2'b01; rw = 1'b1; end
      ALUWB:    rw = 1'b1;
      EXECR:    begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
      EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
      JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      BRANCH:   begin ALUSrcA = 2'b10; ALUOp = 2'b01; branch = 1'b1; end
      default:  ;
    endcase
  end
  // write strobes are gated by RST so nothing fires while reset is held in FETCH
  assign PCWrite   = RST & (pc_update | (branch & (Zero ^ funct3_0)));
  assign IRWrite   = RST & irw;
  assign MemWrite  = RST & mw;
  assign RegWrite  = RST & rw;
  assign IllegalOp = RST & (state == DECODE) & ~supported;
  assign ImmSrc    = opcode == OP_SW  ? 2'b01 :
                     opcode == OP_BR  ? 2'b10 :
                     opcode == OP_JAL ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: scoreboard bench; per-instruction step lists model the expected strobes.
module tb_multicycle_control_fsm;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011;
  logic CLK = 1'b0, RST = 1'b0, funct3_0 = 1'b0, Zero = 1'b0, rdy = 1'b1;
  logic [6:0] opcode = OP_R;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
`ifdef MEM_WAIT_EN
  logic MemReady;
  assign MemReady = rdy;
  int stall = 3;
`endif
  typedef struct {logic [15:0] v; byte s;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [15:0] mon_a;
  int tests = 0, fails = 0;
  always #5 CLK = ~CLK;
  multicycle_control_fsm dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct3_0(funct3_0), .Zero(Zero),
`ifdef MEM_WAIT_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .IllegalOp(IllegalOp)
  );
  function automatic logic supported(logic [6:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR};
  endfunction
  // F fetch, D decode, A address, R read, M load writeback, S store, X reg op, I imm op, J jal, W alu writeback, B branch
  function automatic string steps_of(logic [6:0] op);
    return op == OP_LW ? "FDARM" : op == OP_SW ? "FDAS" : op == OP_R ? "FDXW" :
           op == OP_I ? "FDIW" : op == OP_JAL ? "FDJW" : op == OP_BR ? "FDB" : "FD";
  endfunction
  function automatic logic [15:0] model(byte s, logic [6:0] op, logic z, logic f3, logic r);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] res = 0, sa = 0, sb = 0, aop = 0, imm;
    imm = op == OP_SW ? 2'b01 : op == OP_BR ? 2'b10 : op == OP_JAL ? 2'b11 : 2'b00;
    case (s)
      "F": begin irw = r; pcw = r; sb = 2; res = 2; end
      "D": begin sa = 1; sb = 1; ill = !supported(op); end
      "A": begin sa = 2; sb = 1; end
      "R": adr = 1;
      "S": begin adr = 1; mw = 1; end
      "M": begin res = 1; rw = 1; end
      "W": rw = 1;
      "X": begin sa = 2; aop = 2; end
      "I": begin sa = 2; sb = 1; aop = 2; end
      "J": begin sa = 1; sb = 2; pcw = 1; end
      "B": begin sa = 2; aop = 1; pcw = z ^ f3; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, res, sa, sb, aop, imm, rw, ill};
  endfunction
  function automatic logic [15:0] actual();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, IllegalOp};
  endfunction
  task automatic push(byte s);
    exp_t e;
    e.v = model(s, opcode, Zero, funct3_0, rdy);
    e.s = s;
    q.push_back(e);
  endtask
  always @(negedge CLK)
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = actual();
      tests++;
      if (mon_a !== mon_e.v) begin
        fails++;
        $display("FAIL step_%c op=%b: got %h expected %h", mon_e.s, opcode, mon_a, mon_e.v);
      end
    end
  // in reset the state reads as FETCH but every write strobe must be held low
  task automatic check_reset(string name);
    logic [15:0] e;
    e = model("F", opcode, Zero, funct3_0, 1'b1) & 16'h4FFC;
    tests++;
    if (actual() !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, actual(), e);
    end
  endtask
  task automatic run_seq(logic [6:0] op, logic f3, int zmode, string st);
    opcode = op;
    funct3_0 = f3;
    for (int i = 0; i < st.len(); i++) begin
      byte s;
      s = st[i];
      do begin
        Zero = zmode == 2 ? 1'($urandom) : 1'(zmode);
`ifdef MEM_WAIT_EN
        if (stall > 0 && s == "F") begin rdy = 1'b0; stall--; end
        else rdy = (s == "F" || s == "R" || s == "S") ? ($urandom_range(0, 3) != 0) : 1'b1;
`endif
        push(s);
        @(posedge CLK);
        #1;
      end while (!rdy);
    end
  endtask
  task automatic run_instr(logic [6:0] op, logic f3, int zmode);
    run_seq(op, f3, zmode, steps_of(op));
  endtask
  initial begin
    logic [6:0] op;
    #3 check_reset("reset_initial");
    @(posedge CLK);
    #1 check_reset("reset_hold");
    RST = 1'b1;
    run_instr(OP_LW, 1'b0, 2);
    run_instr(OP_SW, 1'b0, 2);
    run_instr(OP_BR, 1'b0, 1);
    run_instr(OP_BR, 1'b1, 1);
    run_instr(OP_BR, 1'b0, 0);
    run_instr(OP_BR, 1'b1, 0);
    run_instr(OP_JAL, 1'b0, 2);
    run_instr(7'b1111111, 1'b0, 2);
    run_instr(OP_R, 1'b1, 2);
    run_instr(OP_I, 1'b0, 2);
    run_seq(OP_R, 1'b0, 2, "FD");
    Zero = 1'b0;
    push("X");
    @(negedge CLK);
    #2 RST = 1'b0;
    #1 check_reset("reset_mid_execr");
    @(posedge CLK);
    #1 check_reset("reset_held_edge");
    RST = 1'b1;
    repeat (300) begin
      case ($urandom_range(0, 6))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_I;
        4: op = OP_JAL;
        5: op = OP_BR;
        default: do op = 7'($urandom); while (supported(op));
      endcase
      run_instr(op, 1'($urandom), 2);
    end
    @(posedge CLK);
    #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
